// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential WIDTH-bit multiply/divide unit with HI/LO results.
// Multiply is shift-add and divide is restoring, one bit per clock, both on
// operand magnitudes with a final sign-correction step.
// Optional feature macro: MULDIV_DIV_EN. When it is defined the divider is
// built; when it is undefined every divide request finishes one cycle after
// acceptance with hi/lo unchanged and div_zero low.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam int W2 = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      CALC = 2'b01,
      FIX  = 2'b10,
      DONE = 2'b11
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [CW-1:0]    count;
   logic [CW-1:0]    count_nxt;
   logic [W2-1:0]    acc;
   logic [W2-1:0]    acc_nxt;
   logic [W2-1:0]    mul_step;
   logic [W2-1:0]    prod;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH-1:0] mag_b;
   logic [WIDTH-1:0] mag_b_nxt;
   logic [WIDTH-1:0] hi_nxt;
   logic [WIDTH-1:0] lo_nxt;
   logic             sign_a;
   logic             sign_b;
   logic             neg_res;
   logic             neg_res_nxt;
   logic             early;
   logic             early_nxt;
   logic             busy_nxt;
   logic             done_nxt;
   logic             div_zero_nxt;
`ifdef MULDIV_DIV_EN
   logic             is_div;
   logic             is_div_nxt;
   logic             neg_rem;
   logic             neg_rem_nxt;
   logic             dz_pend;
   logic             dz_pend_nxt;
   logic             div_ge;
   logic [WIDTH:0]   div_shift;
   logic [W2-1:0]    div_step;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
`endif

   // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1).
   function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
      if (neg) begin
         magnitude = ~v + WIDTH'(1);
      end else begin
         magnitude = v;
      end
   endfunction

   // One shift-add multiply iteration: acc = {partial product, remaining multiplier bits}.
   always_comb begin
      mul_sum = {1'b0, acc[W2-1:WIDTH]} + {1'b0, mag_b};
      if (acc[0]) begin
         mul_step = {mul_sum, acc[WIDTH-1:1]};
      end else begin
         mul_step = {1'b0, acc[W2-1:1]};
      end
   end

`ifdef MULDIV_DIV_EN
   // One restoring-division iteration: acc = {partial remainder, dividend/quotient bits}.
   always_comb begin
      div_shift = acc[W2-1:WIDTH-1];
      div_ge    = (div_shift >= {1'b0, mag_b});
      if (div_ge) begin
         div_step = {div_shift[WIDTH-1:0] - mag_b, acc[WIDTH-2:0], 1'b1};
      end else begin
         div_step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      end
   end
`endif

   // Next-state and next-output logic for the control FSM and datapath.
   always_comb begin
      state_nxt    = state;
      count_nxt    = count;
      acc_nxt      = acc;
      mag_b_nxt    = mag_b;
      neg_res_nxt  = neg_res;
      early_nxt    = early;
      busy_nxt     = busy;
      done_nxt     = 1'b0;
      div_zero_nxt = div_zero;
      hi_nxt       = hi;
      lo_nxt       = lo;
      prod         = {W2{1'b0}};
      sign_a       = ~op[0] & a[WIDTH-1];
      sign_b       = ~op[0] & b[WIDTH-1];
`ifdef MULDIV_DIV_EN
      is_div_nxt   = is_div;
      neg_rem_nxt  = neg_rem;
      dz_pend_nxt  = dz_pend;
      quo          = acc[WIDTH-1:0];
      rem          = acc[W2-1:WIDTH];
`endif
      case (state)
         IDLE: begin
            if (start) begin
               busy_nxt    = 1'b1;
               neg_res_nxt = sign_a ^ sign_b;
               mag_b_nxt   = magnitude(b, sign_b);
               acc_nxt     = {{WIDTH{1'b0}}, magnitude(a, sign_a)};
`ifdef MULDIV_DIV_EN
               is_div_nxt  = op[1];
               neg_rem_nxt = sign_a;
               if (op[1] && (b == {WIDTH{1'b0}})) begin
                  state_nxt   = DONE;
                  early_nxt   = 1'b1;
                  dz_pend_nxt = 1'b1;
               end else begin
                  state_nxt   = CALC;
                  count_nxt   = CW'(WIDTH);
               end
`else
               if (op[1]) begin
                  state_nxt = DONE;
                  early_nxt = 1'b1;
               end else begin
                  state_nxt = CALC;
                  count_nxt = CW'(WIDTH);
               end
`endif
            end else begin
               state_nxt = IDLE;
            end
         end
         CALC: begin
            count_nxt = count - CW'(1);
`ifdef MULDIV_DIV_EN
            if (is_div) begin
               acc_nxt = div_step;
            end else begin
               acc_nxt = mul_step;
            end
`else
            acc_nxt = mul_step;
`endif
            if (count == CW'(1)) begin
               state_nxt = FIX;
            end else begin
               state_nxt = CALC;
            end
         end
         FIX: begin
            // Results are written only here, on the FIX->DONE edge.
`ifdef MULDIV_DIV_EN
            if (is_div) begin
               lo_nxt = neg_res ? (~quo + WIDTH'(1)) : quo;
               hi_nxt = neg_rem ? (~rem + WIDTH'(1)) : rem;
            end else begin
               prod   = neg_res ? (~acc + W2'(1)) : acc;
               hi_nxt = prod[W2-1:WIDTH];
               lo_nxt = prod[WIDTH-1:0];
            end
`else
            prod   = neg_res ? (~acc + W2'(1)) : acc;
            hi_nxt = prod[W2-1:WIDTH];
            lo_nxt = prod[WIDTH-1:0];
`endif
            done_nxt  = 1'b1;
            state_nxt = DONE;
         end
         DONE: begin
            // Early entries (divide by zero / divider absent) wait one cycle
            // before pulsing done so it lands one edge after acceptance.
            if (early) begin
               early_nxt    = 1'b0;
               done_nxt     = 1'b1;
`ifdef MULDIV_DIV_EN
               div_zero_nxt = dz_pend;
               dz_pend_nxt  = 1'b0;
`else
               div_zero_nxt = 1'b0;
`endif
               state_nxt    = DONE;
            end else begin
               done_nxt     = 1'b0;
               div_zero_nxt = 1'b0;
               busy_nxt     = 1'b0;
               state_nxt    = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
         end
      endcase
   end

   // Control FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count    <= {CW{1'b0}};
         acc      <= {W2{1'b0}};
         mag_b    <= {WIDTH{1'b0}};
         neg_res  <= 1'b0;
         early    <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= {WIDTH{1'b0}};
         lo       <= {WIDTH{1'b0}};
`ifdef MULDIV_DIV_EN
         is_div   <= 1'b0;
         neg_rem  <= 1'b0;
         dz_pend  <= 1'b0;
`endif
      end else begin
         count    <= count_nxt;
         acc      <= acc_nxt;
         mag_b    <= mag_b_nxt;
         neg_res  <= neg_res_nxt;
         early    <= early_nxt;
         busy     <= busy_nxt;
         done     <= done_nxt;
         div_zero <= div_zero_nxt;
         hi       <= hi_nxt;
         lo       <= lo_nxt;
`ifdef MULDIV_DIV_EN
         is_div   <= is_div_nxt;
         neg_rem  <= neg_rem_nxt;
         dz_pend  <= dz_pend_nxt;
`endif
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with literal expectations, plus a
// transaction-level reference model compared against the DUT every cycle.
// Follows the MULDIV_DIV_EN setting of the build for divide expectations.
module tb_muldiv_unit;
   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic         div_zero;
   logic [W-1:0] hi;
   logic [W-1:0] lo;

   int n_checks = 0;
   int n_fail   = 0;
   bit run      = 1'b0;

   always #5 clk = ~clk;

   muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
      .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
   );

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Result of one operation computed from plain arithmetic.
   function automatic void compute(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                   output int lat, output logic dz, output logic upd,
                                   output logic [W-1:0] rh, output logic [W-1:0] rl);
      logic [2*W-1:0] p;
      longint sx, sy, q, r;
      lat = W + 1; dz = 1'b0; upd = 1'b1; rh = '0; rl = '0;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      case (o)
         2'b00: begin
            p = sx * sy;
            rh = p[2*W-1:W]; rl = p[W-1:0];
         end
         2'b01: begin
            p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
            rh = p[2*W-1:W]; rl = p[W-1:0];
         end
         default: begin
`ifdef MULDIV_DIV_EN
            if (y == '0) begin
               lat = 1; dz = 1'b1; upd = 1'b0;
            end else if (o == 2'b10) begin
               q = sx / sy; r = sx % sy;
               rl = q[W-1:0]; rh = r[W-1:0];
            end else begin
               rl = x / y; rh = x % y;
            end
`else
            lat = 1; upd = 1'b0;
`endif
         end
      endcase
   endfunction

   // Reference model: tracks acceptance edge and when results appear.
   int           edge_cnt;
   int           done_at;
   logic         m_busy, m_done, m_dz, r_dz, r_upd;
   logic [W-1:0] m_hi, m_lo, r_hi, r_lo;

   always @(posedge clk or posedge reset) begin : model
      int           t_lat;
      logic         t_dz, t_upd;
      logic [W-1:0] t_hi, t_lo;
      if (reset) begin
         edge_cnt <= 0; done_at <= -10;
         m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
         m_hi <= '0; m_lo <= '0;
         r_dz <= 1'b0; r_upd <= 1'b0; r_hi <= '0; r_lo <= '0;
      end else begin
         edge_cnt <= edge_cnt + 1;
         if (!m_busy) begin
            if (start) begin
               compute(op, a, b, t_lat, t_dz, t_upd, t_hi, t_lo);
               m_busy  <= 1'b1;
               done_at <= edge_cnt + 1 + t_lat;
               r_dz <= t_dz; r_upd <= t_upd; r_hi <= t_hi; r_lo <= t_lo;
            end
         end else if (edge_cnt + 1 == done_at) begin
            m_done <= 1'b1;
            m_dz   <= r_dz;
            if (r_upd) begin
               m_hi <= r_hi; m_lo <= r_lo;
            end
         end else if (edge_cnt + 1 == done_at + 1) begin
            m_done <= 1'b0; m_dz <= 1'b0; m_busy <= 1'b0;
         end
      end
   end

   // Every-cycle comparison of DUT outputs against the model.
   always @(negedge clk) begin
      if (run) begin
         check("busy", 64'(busy), 64'(m_busy));
         check("done", 64'(done), 64'(m_done));
         check("div_zero", 64'(div_zero), 64'(m_dz));
         check("hi", 64'(hi), 64'(m_hi));
         check("lo", 64'(lo), 64'(m_lo));
      end
   end

   task automatic wait_idle();
      for (int k = 0; k < 200 && busy; k++) begin
         @(posedge clk); #1;
      end
      check("idle_wait", 64'(busy), 64'd0);
   endtask

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output logic dz_at_done);
      bit seen;
      wait_idle();
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0; lat = 0; dz_at_done = 1'b0;
      for (int k = 1; k <= 100 && !seen; k++) begin
         @(posedge clk); #1;
         if (done) begin
            seen = 1'b1; lat = k; dz_at_done = div_zero;
         end
      end
      check("done_seen", 64'(seen), 64'd1);
      @(posedge clk); #1;
      check("done_one_cycle", 64'(done), 64'd0);
      check("busy_after", 64'(busy), 64'd0);
   endtask

   logic [1:0]   t_op  [10];
   logic [W-1:0] t_a   [10];
   logic [W-1:0] t_b   [10];
   int           t_lat [10];
   logic         t_dz  [10];
   logic [W-1:0] t_hi  [10];
   logic [W-1:0] t_lo  [10];

   initial begin
      int   lat;
      logic dz;
      bit   seen;

      t_op[0] = 2'b00; t_a[0] = 32'hFFFF_FFFE; t_b[0] = 32'h0000_0003; t_lat[0] = 33; t_dz[0] = 1'b0; t_hi[0] = 32'hFFFF_FFFF; t_lo[0] = 32'hFFFF_FFFA;
      t_op[1] = 2'b01; t_a[1] = 32'hFFFF_FFFF; t_b[1] = 32'hFFFF_FFFF; t_lat[1] = 33; t_dz[1] = 1'b0; t_hi[1] = 32'hFFFF_FFFE; t_lo[1] = 32'h0000_0001;
      t_op[2] = 2'b00; t_a[2] = 32'hFFFF_FFFF; t_b[2] = 32'hFFFF_FFFF; t_lat[2] = 33; t_dz[2] = 1'b0; t_hi[2] = 32'h0000_0000; t_lo[2] = 32'h0000_0001;
      t_op[3] = 2'b10; t_a[3] = 32'hFFFF_FFF9; t_b[3] = 32'h0000_0002;
      t_op[4] = 2'b11; t_a[4] = 32'h0000_0007; t_b[4] = 32'h0000_0002;
      t_op[5] = 2'b10; t_a[5] = 32'h8000_0000; t_b[5] = 32'hFFFF_FFFF;
      t_op[6] = 2'b11; t_a[6] = 32'h0000_0005; t_b[6] = 32'h0000_0000;
`ifdef MULDIV_DIV_EN
      t_lat[3] = 33; t_dz[3] = 1'b0; t_hi[3] = 32'hFFFF_FFFF; t_lo[3] = 32'hFFFF_FFFD;
      t_lat[4] = 33; t_dz[4] = 1'b0; t_hi[4] = 32'h0000_0001; t_lo[4] = 32'h0000_0003;
      t_lat[5] = 33; t_dz[5] = 1'b0; t_hi[5] = 32'h0000_0000; t_lo[5] = 32'h8000_0000;
      t_lat[6] = 1;  t_dz[6] = 1'b1; t_hi[6] = 32'h0000_0000; t_lo[6] = 32'h8000_0000;
`else
      t_lat[3] = 1;  t_dz[3] = 1'b0; t_hi[3] = 32'h0000_0000; t_lo[3] = 32'h0000_0001;
      t_lat[4] = 1;  t_dz[4] = 1'b0; t_hi[4] = 32'h0000_0000; t_lo[4] = 32'h0000_0001;
      t_lat[5] = 1;  t_dz[5] = 1'b0; t_hi[5] = 32'h0000_0000; t_lo[5] = 32'h0000_0001;
      t_lat[6] = 1;  t_dz[6] = 1'b0; t_hi[6] = 32'h0000_0000; t_lo[6] = 32'h0000_0001;
`endif
      t_op[7] = 2'b00; t_a[7] = 32'h0000_0005; t_b[7] = 32'hFFFF_FFFD; t_lat[7] = 33; t_dz[7] = 1'b0; t_hi[7] = 32'hFFFF_FFFF; t_lo[7] = 32'hFFFF_FFF1;
      t_op[8] = 2'b00; t_a[8] = 32'h8000_0000; t_b[8] = 32'h8000_0000; t_lat[8] = 33; t_dz[8] = 1'b0; t_hi[8] = 32'h4000_0000; t_lo[8] = 32'h0000_0000;
      t_op[9] = 2'b01; t_a[9] = 32'h8000_0000; t_b[9] = 32'h0000_0002; t_lat[9] = 33; t_dz[9] = 1'b0; t_hi[9] = 32'h0000_0001; t_lo[9] = 32'h0000_0000;

      reset = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      #1 reset = 1'b1;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      run = 1'b1;

      for (int i = 0; i < 10; i++) begin
         run_op(t_op[i], t_a[i], t_b[i], lat, dz);
         check($sformatf("lat_%0d", i), 64'(lat), 64'(t_lat[i]));
         check($sformatf("dz_%0d", i), 64'(dz), 64'(t_dz[i]));
         check($sformatf("hi_%0d", i), 64'(hi), 64'(t_hi[i]));
         check($sformatf("lo_%0d", i), 64'(lo), 64'(t_lo[i]));
      end

      // A start pulse while busy must be ignored.
      wait_idle();
      start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      start = 1'b1; a = 32'd100; b = 32'd100;
      @(posedge clk); #1;
      start = 1'b0;
      seen = 1'b0; lat = 0;
      for (int k = 6; k <= 100 && !seen; k++) begin
         @(posedge clk); #1;
         if (done) begin
            seen = 1'b1; lat = k;
         end
      end
      check("ign_lat", 64'(lat), 64'd33);
      check("ign_lo", 64'(lo), 64'd42);
      check("ign_hi", 64'(hi), 64'd0);
      @(posedge clk); #1;

      // Reset in the middle of an operation.
      wait_idle();
      start = 1'b1; op = 2'b01; a = 32'h0000_1234; b = 32'h0000_0010;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (10) @(posedge clk);
      #1 reset = 1'b1;
      #1;
      check("mid_rst_busy", 64'(busy), 64'd0);
      check("mid_rst_done", 64'(done), 64'd0);
      check("mid_rst_hi", 64'(hi), 64'd0);
      check("mid_rst_lo", 64'(lo), 64'd0);
      @(posedge clk); #1 reset = 1'b0;
      run_op(2'b01, 32'h0000_1234, 32'h0000_0010, lat, dz);
      check("post_rst_lat", 64'(lat), 64'd33);
      check("post_rst_lo", 64'(lo), 64'h0001_2340);
      check("post_rst_hi", 64'(hi), 64'd0);

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
